// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
// Instruction fetch sequencer for a combinational instruction memory.
// Keeps a byte PC and a 2-entry {pc, word} FIFO whose head drives the
// registered decode interface. Redirects flush the FIFO and restart fetch.
// Optional macro IMEM_FETCH_BOUND_CHECK_EN: out-of-range fetches stop the
// sequencer in a sticky FAULT state instead of wrapping the word index.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_fetch_ctrl #(
  parameter int          IMEM_WORDS = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        fetch_fault
);

  localparam logic [31:0] WORDS_U  = 32'(IMEM_WORDS);
  localparam logic [0:0]  ST_FETCH = 1'b0;
  localparam logic [0:0]  ST_FAULT = 1'b1;

  logic [0:0]  state;
  logic [0:0]  state_nxt;
  logic [31:0] pc;
  logic [1:0]  count;
  logic [31:0] tail_pc;
  logic [31:0] tail_data;
  logic        pop;
  logic        want_push;
  logic        push;
  logic        push_allowed;
  logic        out_of_range;

  // Byte-offset bits of a redirect target are architecturally ignored.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid && instr_ready;

  // A fetch is attempted whenever a FIFO slot is (or becomes) free this cycle.
  assign want_push = push_allowed && !redirect_valid &&
                     ((count != 2'd2) || pop);

`ifdef IMEM_FETCH_BOUND_CHECK_EN
  assign imem_addr    = {2'b00, pc[31:2]};
  assign out_of_range = ({2'b00, pc[31:2]} >= WORDS_U);
`else
  assign imem_addr    = {2'b00, pc[31:2]} % WORDS_U;
  assign out_of_range = 1'b0;
`endif

  assign push = want_push && !out_of_range;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a redirect always resumes fetching; a blocked fetch faults.
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = ST_FETCH;
    end else if (want_push && out_of_range) begin
      state_nxt = ST_FAULT;
    end
  end

  // State-decoded outputs: fault is sticky exactly while in FAULT.
  always_comb begin
    push_allowed = (state != ST_FAULT);
`ifdef IMEM_FETCH_BOUND_CHECK_EN
    fetch_fault  = (state == ST_FAULT);
`else
    fetch_fault  = 1'b0;
`endif
  end

  // PC and FIFO update; the head entry is the registered decode output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      count      <= 2'd0;
      instr_pc   <= 32'd0;
      instr_data <= 32'd0;
      tail_pc    <= 32'd0;
      tail_data  <= 32'd0;
    end else if (redirect_valid) begin
      pc    <= {redirect_pc[31:2], 2'b00};
      count <= 2'd0;
    end else begin
      if (push) begin
        pc <= pc + 32'd4;
      end
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            instr_pc   <= pc;
            instr_data <= imem_rdata;
            count      <= 2'd1;
          end else begin
            tail_pc    <= pc;
            tail_data  <= imem_rdata;
            count      <= 2'd2;
          end
        end
        2'b01: begin
          if (count == 2'd2) begin
            instr_pc   <= tail_pc;
            instr_data <= tail_data;
          end
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            instr_pc   <= tail_pc;
            instr_data <= tail_data;
            tail_pc    <= pc;
            tail_data  <= imem_rdata;
          end else begin
            instr_pc   <= pc;
            instr_data <= imem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter IMEM_WORDS, default 32: number of 32-bit words in the instruction memory being sequenced.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_addr  output  32  word index presented to the combinational instruction memory.
REQ-006 imem_rdata  input  32  instruction word returned combinationally for imem_addr.
REQ-007 redirect_valid  input  1  branch/jump redirect request from the pipeline.
REQ-008 redirect_pc  input  32  redirect byte address; bits [1:0] ignored.
REQ-009 instr_valid  output  1  instr_data/instr_pc hold a valid fetched instruction.
REQ-010 instr_ready  input  1  decode accepts the instruction this cycle.
REQ-011 instr_data  output  32  oldest buffered instruction word.
REQ-012 instr_pc  output  32  byte address of instr_data.
REQ-013 fetch_fault  output  1  sticky out-of-range fetch flag.

Function
REQ-014 The block SHALL hold a byte program counter pc and a 2-entry FIFO of {pc, word} pairs.
REQ-015 imem_addr SHALL equal pc[31:2] (word index, zero-extended).
REQ-016 A push SHALL occur in state FETCH when count<2, or when count==2 and a pop occurs in the same cycle; a push stores {pc, imem_rdata} and sets pc <= pc+4.
REQ-017 A pop SHALL occur when instr_valid && instr_ready; instr_valid = (count != 0).
REQ-018 instr_data/instr_pc SHALL be driven from the FIFO head, registered, zero combinational path from imem_rdata.
REQ-019 Fetch-to-output latency SHALL be one cycle: a word pushed at edge N is visible at the head after edge N when the FIFO was empty.
REQ-020 Sustained throughput SHALL be one instruction per cycle while instr_ready is held high.
REQ-021 instr_data/instr_pc SHALL remain stable while instr_valid && !instr_ready.
REQ-022 redirect_valid SHALL take priority over push and pop: FIFO flushed (count<=0), pc <= {redirect_pc[31:2],2'b00}, state <= FETCH, fetch_fault <= 0; instr_valid low the following cycle.
REQ-023 The fetch at redirect_pc SHALL be pushed on the first edge after the redirect edge.
REQ-024 pc SHALL wrap modulo 2^32 on increment.
REQ-025 States: FETCH (pushes permitted) and FAULT (no pushes; FIFO drains normally); FAULT exits only via redirect or reset.

Reset
REQ-026 On rst_n low, asynchronously: pc <= RESET_PC, count <= 0, state <= FETCH, fetch_fault <= 0, instr_valid <= 0, instr_data <= 0, instr_pc <= 0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered instructions; the first push after release SHALL be at RESET_PC.

Configuration
REQ-028 Macro IMEM_FETCH_BOUND_CHECK_EN defined: when a push would occur with pc[31:2] >= IMEM_WORDS, no push occurs, state <= FAULT, fetch_fault <= 1 on that edge.
REQ-029 Macro IMEM_FETCH_BOUND_CHECK_EN undefined: imem_addr = pc[31:2] mod IMEM_WORDS, no FAULT entry, fetch_fault tied 0.

Verification
REQ-030 Reset release, IMEM[0..3]=A,B,C,D, instr_ready=1 -> instr_pc 0,4,8,C on consecutive cycles starting the cycle after the first edge, data A,B,C,D.
REQ-031 instr_ready=0 for 5 cycles after reset -> count saturates at 2, head stays {0,A}, pc stays 8; ready=1 -> 0,4,8 back-to-back with no bubble.
REQ-032 Redirect to 32'h0000_0012 while 2 entries buffered -> next cycle instr_valid=0, following cycle instr_pc=32'h10, data=IMEM[4].
REQ-033 Simultaneous pop and redirect -> popped entry consumed, FIFO empty, no stale entry ever appears after redirect.
REQ-034 Bound check on, IMEM_WORDS=32, redirect to 32'h7C -> IMEM[31] delivered, then fetch_fault=1, instr_valid=0 after drain; redirect to 0 clears fault and restarts at IMEM[0]; bound check off -> pc 32'h80 fetches IMEM[0], fetch_fault stays 0.
REQ-035 rst_n pulsed low mid-stream for a partial cycle -> outputs cleared immediately, first instr_pc after release = RESET_PC.
